// File: rtl/square_list_to_bitboard_if.sv
// Stream interface for square_list_to_bitboard: binary index beats in, one bitboard per list out.
// The block itself connects through the slave modport; a producer/consumer pair uses master.
interface square_list_to_bitboard_if #(
  parameter int BOARD_SQUARES = 64
);
  localparam int IDX_WIDTH = $clog2(BOARD_SQUARES);
  localparam int CNT_WIDTH = $clog2(BOARD_SQUARES + 1);

  logic                     in_valid;
  logic                     in_ready;
  logic [IDX_WIDTH-1:0]     in_index;
  logic                     in_last;
  logic                     out_valid;
  logic                     out_ready;
  logic [BOARD_SQUARES-1:0] out_bitboard;
  logic [CNT_WIDTH-1:0]     out_count;
  logic                     out_dup;
  logic                     out_err;

  modport master (
    output in_valid, in_index, in_last, out_ready,
    input  in_ready, out_valid, out_bitboard, out_count, out_dup, out_err
  );

  modport slave (
    input  in_valid, in_index, in_last, out_ready,
    output in_ready, out_valid, out_bitboard, out_count, out_dup, out_err
  );
endinterface

// File: rtl/square_list_to_bitboard.sv
// Accumulates a list of binary square indices into a one-hot bitboard with distinct-count,
// duplicate and out-of-range flags; a holding register lets the next list build while one waits.
module square_list_to_bitboard #(
  parameter int BOARD_SQUARES = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  square_list_to_bitboard_if.slave     bus
);
  localparam int IDX_WIDTH = $clog2(BOARD_SQUARES);
  localparam int CNT_WIDTH = $clog2(BOARD_SQUARES + 1);

  logic [BOARD_SQUARES-1:0] acc_q, acc_d;
  logic [CNT_WIDTH-1:0]     acc_count_q, acc_count_d;
  logic                     acc_dup_q, acc_dup_d;
  logic                     acc_err_q, acc_err_d;

  logic                     out_valid_q;
  logic [BOARD_SQUARES-1:0] out_bitboard_q;
  logic [CNT_WIDTH-1:0]     out_count_q;
  logic                     out_dup_q;
  logic                     out_err_q;

  logic                     accept;
  logic                     idx_oob;
  logic [BOARD_SQUARES-1:0] idx_onehot;
  logic                     idx_hit;

  // Out-of-range indices only exist when the index field can encode more than BOARD_SQUARES values.
  if ((1 << IDX_WIDTH) > BOARD_SQUARES) begin : g_range_check
    assign idx_oob = bus.in_index > IDX_WIDTH'(BOARD_SQUARES - 1);
  end else begin : g_no_range_check
    assign idx_oob = 1'b0;
  end

  assign bus.in_ready = ~out_valid_q | bus.out_ready;
  assign accept       = bus.in_valid & bus.in_ready;

  // A shift past the top of the vector yields zero, so an out-of-range index sets no bit.
  assign idx_onehot = {{(BOARD_SQUARES-1){1'b0}}, 1'b1} << bus.in_index;
  assign idx_hit    = |(acc_q & idx_onehot);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    acc_d       = acc_q | idx_onehot;
    acc_count_d = acc_count_q;
    acc_dup_d   = acc_dup_q | idx_hit;
    acc_err_d   = acc_err_q | idx_oob;
    if (!idx_oob && !idx_hit) begin
      acc_count_d = acc_count_q + CNT_WIDTH'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q          <= '0;
      acc_count_q    <= '0;
      acc_dup_q      <= 1'b0;
      acc_err_q      <= 1'b0;
      out_valid_q    <= 1'b0;
      out_bitboard_q <= '0;
      out_count_q    <= '0;
      out_dup_q      <= 1'b0;
      out_err_q      <= 1'b0;
    end else begin
      if (accept) begin
        if (bus.in_last) begin
          acc_q       <= '0;
          acc_count_q <= '0;
          acc_dup_q   <= 1'b0;
          acc_err_q   <= 1'b0;
        end else begin
          acc_q       <= acc_d;
          acc_count_q <= acc_count_d;
          acc_dup_q   <= acc_dup_d;
          acc_err_q   <= acc_err_d;
        end
      end

      // A completing list reloads the holding register even while the old result drains.
      if (accept && bus.in_last) begin
        out_valid_q    <= 1'b1;
        out_bitboard_q <= acc_d;
        out_count_q    <= acc_count_d;
        out_dup_q      <= acc_dup_d;
        out_err_q      <= acc_err_d;
      end else if (bus.out_ready) begin
        out_valid_q    <= 1'b0;
      end
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.out_bitboard = out_bitboard_q;
  assign bus.out_count    = out_count_q;
  assign bus.out_dup      = out_dup_q;
  assign bus.out_err      = out_err_q;
endmodule

// File: tb/tb_square_list_to_bitboard.sv
// Bench for square_list_to_bitboard: directed scenarios plus randomized lists scored
// against a set-based model; a second 48-square instance covers out-of-range indices.
module tb_square_list_to_bitboard;
  localparam int BS    = 64;
  localparam int IDX_W = 6;
  localparam int CNT_W = 7;

  typedef struct {
    logic [63:0] bb;
    int          cnt;
    bit          dup;
    bit          err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   rand_ready = 1'b0;

  int   cur[$];
  exp_t exp_q[$];

  square_list_to_bitboard_if #(.BOARD_SQUARES(BS)) bus ();
  square_list_to_bitboard_if #(.BOARD_SQUARES(48)) bus48 ();

  square_list_to_bitboard #(.BOARD_SQUARES(BS)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  square_list_to_bitboard #(.BOARD_SQUARES(48)) u_dut48 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus48)
  );

  always #5 clk = ~clk;

  // Reference: bitboard is the set of in-range indices seen; count is its cardinality.
  function automatic exp_t model(input int idx_q[$], input int bs);
    exp_t e;
    bit   seen[int];
    e.bb = '0; e.cnt = 0; e.dup = 0; e.err = 0;
    foreach (idx_q[k]) begin
      if (idx_q[k] >= bs) e.err = 1;
      else if (seen.exists(idx_q[k])) e.dup = 1;
      else begin
        seen[idx_q[k]] = 1;
        e.bb[idx_q[k]] = 1'b1;
        e.cnt++;
      end
    end
    return e;
  endfunction

  // Scoreboard: records accepted beats and checks every drained bitboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      cur.delete();
      exp_q.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL sb_unexpected: got bitboard %h, required none pending", bus.out_bitboard);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (bus.out_bitboard !== e.bb || int'(bus.out_count) !== e.cnt ||
              bus.out_dup !== e.dup || bus.out_err !== e.err) begin
            n_bad++;
            $display("FAIL sb_result: got bb=%h cnt=%0d dup=%b err=%b, required bb=%h cnt=%0d dup=%b err=%b",
                     bus.out_bitboard, bus.out_count, bus.out_dup, bus.out_err, e.bb, e.cnt, e.dup, e.err);
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        cur.push_back(int'(bus.in_index));
        if (bus.in_last) begin
          exp_q.push_back(model(cur, BS));
          cur.delete();
        end
      end
    end
  end

  always begin
    @(posedge clk); #1;
    if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called at posedge+1; returns at posedge+1 right after the beat's accepting edge.
  task automatic send_beat(input int idx, input bit last);
    int waited = 0;
    bus.in_valid = 1'b1;
    bus.in_index = IDX_W'(idx);
    bus.in_last  = last;
    @(negedge clk);
    while (!bus.in_ready && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL beat_timeout: in_ready got 0 for index %0d, required 1 within 300 cycles", idx);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic check_result(input string name, input logic [63:0] bb, input int cnt, input bit dup);
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_bitboard !== bb || int'(bus.out_count) !== cnt ||
        bus.out_dup !== dup || bus.out_err !== 1'b0) begin
      n_bad++;
      $display("FAIL %s: got v=%b bb=%h cnt=%0d dup=%b err=%b, required v=1 bb=%h cnt=%0d dup=%b err=0",
               name, bus.out_valid, bus.out_bitboard, bus.out_count, bus.out_dup, bus.out_err, bb, cnt, dup);
    end
  endtask

  task automatic test_reset();
    bus.in_valid = 0; bus.in_index = '0; bus.in_last = 0; bus.out_ready = 0;
    bus48.in_valid = 0; bus48.in_index = '0; bus48.in_last = 0; bus48.out_ready = 1;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.out_valid, bus.out_bitboard, bus.out_count, bus.out_dup, bus.out_err} !== '0 ||
        bus.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_state: got v=%b bb=%h cnt=%0d in_ready=%b, required all 0 and in_ready=1",
               bus.out_valid, bus.out_bitboard, bus.out_count, bus.in_ready);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_basic();
    bus.out_ready = 1'b1;
    send_beat(0, 0);
    send_beat(63, 1);
    check_result("basic_0_63", 64'h8000_0000_0000_0001, 2, 0);
    @(posedge clk); #1;
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_drain: got out_valid=%b, required 0", bus.out_valid);
    end
  endtask

  task automatic test_dup();
    send_beat(12, 0);
    send_beat(12, 0);
    send_beat(28, 1);
    check_result("dup_12_12_28", 64'h0000_0000_1000_1000, 2, 1);
  endtask

  task automatic test_hold();
    logic [63:0] held;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    send_beat(3, 0);
    send_beat(40, 1);
    check_result("hold_first", (64'd1 << 3) | (64'd1 << 40), 2, 0);
    held = bus.out_bitboard;
    bus.in_valid = 1'b1; bus.in_index = IDX_W'(7); bus.in_last = 1'b0;
    repeat (5) begin
      @(negedge clk);
      n_cmp++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_bitboard !== held) begin
        n_bad++;
        $display("FAIL hold_stall: got in_ready=%b v=%b bb=%h, required in_ready=0 v=1 bb=%h",
                 bus.in_ready, bus.out_valid, bus.out_bitboard, held);
      end
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL hold_release: got in_ready=%b, required 1", bus.in_ready);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    send_beat(21, 1);
    check_result("hold_second", (64'd1 << 7) | (64'd1 << 21), 2, 0);
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1; bus.in_index = IDX_W'(i); bus.in_last = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (bus.in_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL b2b_ready: list %0d got in_ready=%b, required 1", i, bus.in_ready);
      end
      @(posedge clk); #1;
      check_result($sformatf("b2b_list_%0d", i), 64'd1 << i, 1, 0);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b1;
    send_beat(5, 0);
    send_beat(6, 0);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.out_valid, bus.out_bitboard, bus.out_count, bus.out_dup, bus.out_err} !== '0) begin
      n_bad++;
      $display("FAIL reset_mid_list: got v=%b bb=%h, required all 0", bus.out_valid, bus.out_bitboard);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    send_beat(9, 1);
    check_result("reset_no_leak", 64'd1 << 9, 1, 0);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    send_beat(2, 1);
    check_result("reset_hold_pre", 64'd1 << 2, 1, 0);
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.out_valid, bus.out_bitboard, bus.out_count, bus.out_dup, bus.out_err} !== '0) begin
      n_bad++;
      $display("FAIL reset_mid_hold: got v=%b bb=%h, required all 0", bus.out_valid, bus.out_bitboard);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    bus.out_ready = 1'b1;
  endtask

  task automatic test_random();
    rand_ready = 1'b1;
    for (int l = 0; l < 40; l++) begin
      int len = $urandom_range(1, 6);
      bit narrow = ($urandom_range(0, 2) == 0);
      for (int b = 0; b < len; b++) begin
        int idx = narrow ? $urandom_range(10, 13) : $urandom_range(0, BS - 1);
        send_beat(idx, b == len - 1);
      end
    end
    rand_ready = 1'b0;
    @(posedge clk); #2;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() !== 0 || cur.size() !== 0) begin
      n_bad++;
      $display("FAIL random_drain: got %0d pending lists / %0d partial beats, required 0 / 0",
               exp_q.size(), cur.size());
    end
  endtask

  task automatic test_non_pow2();
    exp_t e;
    int   lst[$];
    lst = '{47, 50};
    e = model(lst, 48);
    bus48.out_ready = 1'b1;
    bus48.in_valid = 1'b1; bus48.in_index = 6'd47; bus48.in_last = 1'b0;
    @(posedge clk); #1;
    bus48.in_index = 6'd50; bus48.in_last = 1'b1;
    @(posedge clk); #1;
    bus48.in_valid = 1'b0;
    n_cmp++;
    if (bus48.out_valid !== 1'b1 || {16'd0, bus48.out_bitboard} !== e.bb ||
        int'(bus48.out_count) !== e.cnt || bus48.out_err !== 1'b1 || bus48.out_dup !== 1'b0) begin
      n_bad++;
      $display("FAIL oob_48: got v=%b bb=%h cnt=%0d dup=%b err=%b, required v=1 bb=%h cnt=%0d dup=0 err=1",
               bus48.out_valid, bus48.out_bitboard, bus48.out_count, bus48.out_dup, bus48.out_err,
               e.bb, e.cnt);
    end
  endtask

  initial begin
    test_reset();
    @(posedge clk); #1;
    test_basic();
    test_dup();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_non_pow2();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/square_list_to_bitboard.md
Name: square_list_to_bitboard

Overview:
- Streaming binary-to-one-hot accumulator: takes a valid/ready stream of binary square indices (e.g. move targets or piece locations) and builds one bitboard per list, delimited by in_last.
- Inverse partner of the bitboard-to-index encoder. Sits between move-list / search logic and bitboard consumers (attack masks, occupancy compare).
- Two-stage: accumulator register plus output holding register, so the next list accumulates while the previous bitboard waits for out_ready.

Parameters:
- BOARD_SQUARES, 64, bitboard width / number of squares; any value >= 2.
- IDX_WIDTH, $clog2(BOARD_SQUARES), localparam, index width.
- CNT_WIDTH, $clog2(BOARD_SQUARES+1), localparam, population count width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  index beat valid.
- in_ready  out  1  block accepts beat when in_valid & in_ready.
- in_index  in  IDX_WIDTH  binary square index.
- in_last  in  1  beat is final index of current list.
- out_valid  out  1  bitboard available.
- out_ready  in  1  consumer takes bitboard when out_valid & out_ready.
- out_bitboard  out  BOARD_SQUARES  accumulated one-hot OR; bit i set iff index i was received.
- out_count  out  CNT_WIDTH  number of distinct squares set in out_bitboard.
- out_dup  out  1  at least one index in the list repeated an already-set square.
- out_err  out  1  at least one index was >= BOARD_SQUARES, so the beat was dropped.

Behaviour:
- Reset (async, rst_n low): acc, acc_count, acc_dup, acc_err cleared. out_valid=0, out_bitboard=0, out_count=0, out_dup=0, out_err=0. Takes effect immediately, mid-list or mid-hold. Any partial list is discarded.
- in_ready = ~out_valid | out_ready. Combinational; must not depend on in_valid, in_index or in_last.
- Accepted non-last beat, index valid:
  - Bit already set in acc: acc unchanged, acc_dup<=1, count unchanged.
  - Otherwise: acc[idx]<=1, acc_count<=acc_count+1.
- Accepted beat with in_index >= BOARD_SQUARES: no bit set, count unchanged, acc_err<=1. Only reachable when BOARD_SQUARES is not a power of 2.
- Accepted last beat:
  - Same update rules applied combinationally to form the final bitboard/count/dup/err.
  - Final values are loaded into the output registers and out_valid<=1 on the next edge.
  - acc, acc_count, acc_dup and acc_err are cleared on that same edge.
- Latency: last beat accepted at edge N, so out_valid=1 after edge N; the first beat of the next list is accepted at edge N+1 if out_ready permits.
- Output hold: while out_valid & ~out_ready, the output registers stay stable and in_ready=0. The partial accumulator is held, not lost.
- Output drain:
  - out_valid & out_ready with no new last beat accepted: out_valid<=0 next edge.
  - Same cycle as an accepted last beat: output registers reload with the new list and out_valid stays 1. This gives back-to-back throughput of one bitboard per cycle for single-beat lists.
- Single-beat list (in_last on first beat) produces a one-hot bitboard with count=1. There is no empty list.
- Count never exceeds BOARD_SQUARES, since duplicates do not increment it. No wrap is possible.
- out_bitboard, out_count, out_dup and out_err are meaningful only while out_valid=1, but are held registered and stable otherwise.

Test Plan:
- Reset, then list {0, 63(last)} with out_ready=1 -> one cycle after last, out_valid=1, out_bitboard=64'h8000_0000_0000_0001, out_count=2, out_dup=0, out_err=0.
- List {12, 12, 28(last)} -> out_bitboard=64'h0000_0000_1000_1000, out_count=2, out_dup=1.
- out_ready=0 held 5 cycles after a list completes, next list's beats presented -> in_ready=0 throughout, output stable; raise out_ready -> first pending beat accepted that cycle, second bitboard correct.
- Stream of 8 single-beat lists 0..7 with out_ready=1 continuously -> in_ready stays 1, eight consecutive out_valid cycles with bitboards 1<<0 .. 1<<7, count=1 each.
- Assert rst_n low mid-list (after indices 5, 6) and also during out_valid hold -> all outputs 0 immediately. Next list {9(last)} gives exactly 1<<9, count=1, no leakage of 5/6.
- BOARD_SQUARES=48 build, list {47, 50(last)} -> out_bitboard=1<<47, out_count=1, out_err=1.
